clock_time_setter: RTL and testbench
====================================

Name: clock_time_setter

Overview:
- User-input side of the digital clock. Debounces two push-buttons (MODE, INC) and runs a time-set FSM.
- The FSM lets the user edit hours, minutes and seconds as packed BCD, then issues a one-cycle load strobe to the clock counters.
- Sits between the board buttons and the BCD time counters.
- Also exports the edited field and a blink phase so the display path can flash the digits being edited.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (20 ms at 50 MHz).
- TIMEOUT_CYCLES, 500_000_000: idle cycles in edit mode before aborting without load (10 s).
- BLINK_CYCLES, 12_500_000: half-period of blink_on.
- HOLD_CYCLES, 50_000_000: INC hold time before auto-repeat starts (used only with AUTOREPEAT_EN).
- REPEAT_CYCLES, 10_000_000: auto-repeat interval (used only with AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset, asynchronous, active-high
- btn_mode_raw  in  1  raw MODE button, asynchronous, high = pressed
- btn_inc_raw  in  1  raw INC button, asynchronous, high = pressed
- cur_hour  in  8  current hours, BCD: [7:4] tens, [3:0] ones
- cur_min  in  8  current minutes, BCD
- cur_sec  in  8  current seconds, BCD
- set_active  out  1  high while in any edit state
- edit_field  out  2  0 none, 1 hour, 2 min, 3 sec
- set_hour  out  8  edited hours, BCD
- set_min  out  8  edited minutes, BCD
- set_sec  out  8  edited seconds, BCD
- load  out  1  one-cycle strobe; set_* are valid in the same cycle
- blink_on  out  1  blink phase; 0 when not editing

Behaviour:
- Reset: all outputs 0; FSM in IDLE; debouncers released; all counters 0. Reset asserted mid-edit aborts the edit; no load is issued.
- Debounce, per button:
  - 2-flop synchronizer, then a stable counter.
  - The counter clears whenever the synchronized value equals the debounced state, and increments otherwise.
  - When counter == DEBOUNCE_CYCLES-1 and the values still differ, the state flips on the next edge.
  - A 0->1 flip produces a one-cycle press pulse, registered on the same edge as the flip.
  - Pulse latency: DEBOUNCE_CYCLES+2 edges after the first edge that samples the raw input high.
  - Bounces shorter than DEBOUNCE_CYCLES are ignored. Releases produce no pulse.
- FSM states: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
  - IDLE + mode press: capture cur_* into set_*, go to EDIT_HOUR. Any captured field that is invalid (tens/ones outside BCD range, hour > 23, min/sec > 59) becomes 0x00.
  - EDIT_HOUR -> EDIT_MIN -> EDIT_SEC -> COMMIT, each on a mode press.
  - COMMIT: load=1 for exactly one cycle, then IDLE. Presses arriving in the COMMIT cycle are dropped.
  - IDLE ignores inc presses.
- Increment, applied in the edit state's field, one step per press, registered next cycle:
  - Ones digit 9 -> 0 with a carry into tens.
  - Minutes/seconds: 0x59 -> 0x00.
  - Hours: 0x23 -> 0x00; 0x09 -> 0x10; 0x19 -> 0x20.
- Simultaneous mode and inc press in the same cycle: mode wins; the increment is discarded.
- Timeout:
  - The counter clears on entry to EDIT_HOUR and on every press pulse, and counts in all edit states.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, set_active=0, no load. set_* hold their last values.
- edit_field mirrors the state: 1/2/3 in the EDIT states, 0 otherwise.
- set_active=1 in the EDIT states, 0 in IDLE and COMMIT.
- Blink: a counter runs only while set_active. blink_on toggles every BLINK_CYCLES and is forced to 1 on entry and after each press, so edits stay visible.

Optional Feature:
- Macro: CLOCK_TIME_SETTER_AUTOREPEAT_EN.
- Defined:
  - While INC stays debounced-high in an edit state, after HOLD_CYCLES from the press pulse, generate an extra increment every REPEAT_CYCLES until release.
  - Each repeat step also clears the timeout counter.
  - A mode press or a state change stops the repeat.
- Undefined: one increment per press only; the hold/repeat counters are not synthesized and HOLD_CYCLES/REPEAT_CYCLES are unused.

Decomposition:
- Package clock_set_pkg contains:
  - state enum (IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT);
  - edit_field encoding constants FIELD_NONE/HOUR/MIN/SEC;
  - BCD limit constants HOUR_MAX=8'h23 and MINSEC_MAX=8'h59.
- Sub-module button_debouncer (synchronizer, stable counter, press pulse), parameterized by DEBOUNCE_CYCLES and instantiated twice.
- BCD increment is a local function, not a module.

Test Plan (sim parameters DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=1000, BLINK_CYCLES=8, HOLD_CYCLES=20, REPEAT_CYCLES=5):
- Reset, then raw inputs idle 50 cycles -> all outputs 0, no load.
- cur=12:34:56; MODE press -> edit_field=1, set_hour=0x12. 12 INC presses -> set_hour=0x00. 3 MODE presses -> exactly one load cycle with set_hour=0x00, set_min=0x34, set_sec=0x56; edit_field back to 0.
- In EDIT_MIN, starting at 0x09, INC -> 0x10. Starting at 0x59, INC -> 0x00; set_hour unchanged.
- Raw INC high for 3 cycles plus bounce glitches -> no press pulse, value unchanged. Held for 10 cycles -> exactly one increment, pulse DEBOUNCE_CYCLES+2 edges after the first sampled-high edge.
- Enter edit, no presses for 1000 cycles -> set_active falls to 0, load never asserted. Repeat, asserting rst mid-edit -> all outputs 0 immediately.
- MODE and INC pulses in the same cycle in EDIT_HOUR -> edit_field=2, set_hour unchanged. With the macro defined, holding INC for 40 cycles in EDIT_SEC from 0x00 -> 0x05.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Shared types and constants for the clock time-set block: FSM states,
// edit_field encoding, BCD limits and small helpers used by the top.
package clock_set_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EDIT_HOUR = 3'd1,
        EDIT_MIN  = 3'd2,
        EDIT_SEC  = 3'd3,
        COMMIT    = 3'd4
    } state_e;

    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // A packed BCD value is kept only if its ones digit is a decimal digit
    // and the whole value does not exceed the field limit; with a valid ones
    // digit the numeric compare also rejects any out-of-range tens digit.
    function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] max);
        return ((v[3:0] <= 4'd9) && (v <= max)) ? v : 8'h00;
    endfunction

    function automatic logic is_edit(input state_e s);
        return (s == EDIT_HOUR) || (s == EDIT_MIN) || (s == EDIT_SEC);
    endfunction

    function automatic logic [1:0] field_of(input state_e s);
        case (s)
            EDIT_HOUR: return FIELD_HOUR;
            EDIT_MIN:  return FIELD_MIN;
            EDIT_SEC:  return FIELD_SEC;
            default:   return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button debouncer: two-flop synchronizer, a stable-level counter and a
// one-cycle press pulse on each accepted 0->1 change. Releases give no pulse.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count how long the synchronized input has disagreed with the accepted
    // level; accept the new level once it has held for the full window.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Register synchronizer, accepted level, counter and press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/clock_time_setter.sv
// Time-set front end of the digital clock: debounces MODE/INC, walks the
// user through hour/minute/second editing in packed BCD and strobes load.
// Optional auto-repeat on a held INC: define CLOCK_TIME_SETTER_AUTOREPEAT_EN.
module clock_time_setter
    import clock_set_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
    parameter int unsigned BLINK_CYCLES    = 12_500_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000,
    parameter int unsigned REPEAT_CYCLES   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_raw,
    input  logic       btn_inc_raw,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic       set_active,
    output logic [1:0] edit_field,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic       load,
    output logic       blink_on
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

    state_e        state_q, state_d;
    logic [7:0]    set_hour_q, set_hour_d;
    logic [7:0]    set_min_q, set_min_d;
    logic [7:0]    set_sec_q, set_sec_d;
    logic          set_active_q, set_active_d;
    logic [1:0]    edit_field_q, edit_field_d;
    logic          load_q, load_d;
    logic          blink_q, blink_d;
    logic [TW-1:0] timeout_q, timeout_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          mode_press, inc_press, mode_level, inc_level;
    logic          step, rep_step, activity, next_edit;
    logic          unused_levels;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_mode_raw),
        .level (mode_level),
        .press (mode_press)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_inc_raw),
        .level (inc_level),
        .press (inc_press)
    );

    // The MODE level has no consumer, and the INC level is only needed for auto-repeat.
    assign unused_levels = mode_level ^ inc_level;

`ifdef CLOCK_TIME_SETTER_AUTOREPEAT_EN
    localparam int unsigned RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

    logic          rep_armed_q, rep_armed_d;
    logic          rep_running_q, rep_running_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    // Arm on an INC press, wait the hold time, then emit a step every repeat
    // interval while INC stays down; leaving edit or pressing MODE disarms.
    always_comb begin
        rep_armed_d   = rep_armed_q;
        rep_running_d = rep_running_q;
        rep_cnt_d     = rep_cnt_q;
        rep_step      = 1'b0;
        if (!is_edit(state_q) || mode_press) begin
            rep_armed_d   = 1'b0;
            rep_running_d = 1'b0;
            rep_cnt_d     = '0;
        end else if (inc_press) begin
            rep_armed_d   = 1'b1;
            rep_running_d = 1'b0;
            rep_cnt_d     = '0;
        end else if (rep_armed_q && inc_level) begin
            if (rep_cnt_q == (rep_running_q ? REPEAT_LAST : HOLD_LAST)) begin
                rep_step      = 1'b1;
                rep_running_d = 1'b1;
                rep_cnt_d     = '0;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end else begin
            rep_armed_d   = 1'b0;
            rep_running_d = 1'b0;
            rep_cnt_d     = '0;
        end
    end

    // Register the auto-repeat tracking state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_armed_q   <= 1'b0;
            rep_running_q <= 1'b0;
            rep_cnt_q     <= '0;
        end else begin
            rep_armed_q   <= rep_armed_d;
            rep_running_q <= rep_running_d;
            rep_cnt_q     <= rep_cnt_d;
        end
    end
`else
    localparam int unsigned UNUSED_REPEAT_TIMING = HOLD_CYCLES + REPEAT_CYCLES;
    assign rep_step = 1'b0;
`endif

    // Next state and edited values: MODE outranks INC, INC outranks timeout.
    always_comb begin
        state_d    = state_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        step       = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_press) begin
                    state_d    = EDIT_HOUR;
                    set_hour_d = bcd_sanitize(cur_hour, HOUR_MAX);
                    set_min_d  = bcd_sanitize(cur_min, MINSEC_MAX);
                    set_sec_d  = bcd_sanitize(cur_sec, MINSEC_MAX);
                end
            end
            EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
                if (mode_press)
                    state_d = (state_q == EDIT_HOUR) ? EDIT_MIN :
                              (state_q == EDIT_MIN)  ? EDIT_SEC : COMMIT;
                else if (inc_press || rep_step)
                    step = 1'b1;
                else if (timeout_q == TIMEOUT_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (step) begin
            case (state_q)
                EDIT_HOUR: set_hour_d = bcd_inc(set_hour_q, HOUR_MAX);
                EDIT_MIN:  set_min_d  = bcd_inc(set_min_q, MINSEC_MAX);
                EDIT_SEC:  set_sec_d  = bcd_inc(set_sec_q, MINSEC_MAX);
                default:   set_sec_d  = set_sec_q;
            endcase
        end
    end

    // Timeout, blink and decoded outputs all follow the upcoming state so
    // they line up with it; any press or state change restarts the timers.
    always_comb begin
        next_edit    = is_edit(state_d);
        activity     = (state_d != state_q) || step;
        set_active_d = next_edit;
        edit_field_d = field_of(state_d);
        load_d       = (state_d == COMMIT);
        timeout_d    = '0;
        blink_d      = 1'b0;
        blink_cnt_d  = '0;
        if (next_edit) begin
            timeout_d = activity ? '0 : timeout_q + TW'(1);
            if (activity) begin
                blink_d = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
    end

    // Single state/output register bank for the time-set FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            set_hour_q   <= 8'h00;
            set_min_q    <= 8'h00;
            set_sec_q    <= 8'h00;
            set_active_q <= 1'b0;
            edit_field_q <= FIELD_NONE;
            load_q       <= 1'b0;
            blink_q      <= 1'b0;
            timeout_q    <= '0;
            blink_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            set_hour_q   <= set_hour_d;
            set_min_q    <= set_min_d;
            set_sec_q    <= set_sec_d;
            set_active_q <= set_active_d;
            edit_field_q <= edit_field_d;
            load_q       <= load_d;
            blink_q      <= blink_d;
            timeout_q    <= timeout_d;
            blink_cnt_q  <= blink_cnt_d;
        end
    end

    assign set_active = set_active_q;
    assign edit_field = edit_field_q;
    assign set_hour   = set_hour_q;
    assign set_min    = set_min_q;
    assign set_sec    = set_sec_q;
    assign load       = load_q;
    assign blink_on   = blink_q;

endmodule

// File: tb/tb_clock_time_setter.sv
// Bench for clock_time_setter: directed scenarios plus randomized editing
// sessions checked against a decimal-arithmetic model of the time setter.
module tb_clock_time_setter;

    localparam int DEB     = 4;
    localparam int TIMEOUT = 1000;
    localparam int BLINK   = 8;
    localparam int HOLD    = 20;
    localparam int REPEAT  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode_raw = 1'b0;
    logic       btn_inc_raw = 1'b0;
    logic [7:0] cur_hour = 8'h00;
    logic [7:0] cur_min = 8'h00;
    logic [7:0] cur_sec = 8'h00;
    logic       set_active;
    logic [1:0] edit_field;
    logic [7:0] set_hour, set_min, set_sec;
    logic       load;
    logic       blink_on;

    int         n_checks = 0;
    int         n_fail = 0;
    int         load_count = 0;
    int         exp_loads = 0;
    logic [7:0] ld_hour = 8'h00, ld_min = 8'h00, ld_sec = 8'h00;

    // model: field 0 none, 1 hour, 2 min, 3 sec
    int         m_field = 0;
    logic [7:0] m_hour = 8'h00, m_min = 8'h00, m_sec = 8'h00;

    always #10 clk = ~clk;

    clock_time_setter #(
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TIMEOUT),
        .BLINK_CYCLES    (BLINK),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REPEAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_mode_raw (btn_mode_raw),
        .btn_inc_raw  (btn_inc_raw),
        .cur_hour     (cur_hour),
        .cur_min      (cur_min),
        .cur_sec      (cur_sec),
        .set_active   (set_active),
        .edit_field   (edit_field),
        .set_hour     (set_hour),
        .set_min      (set_min),
        .set_sec      (set_sec),
        .load         (load),
        .blink_on     (blink_on)
    );

    // Count load cycles and capture the values presented with each one.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            load_count = load_count + 1;
            ld_hour = set_hour;
            ld_min  = set_min;
            ld_sec  = set_sec;
        end
    end

    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic logic [7:0] m_capture(input logic [7:0] v, input int limit);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || bcd2int(v) > limit)
            return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] m_inc(input logic [7:0] v, input int modulus);
        return int2bcd((bcd2int(v) + 1) % modulus);
    endfunction

    function automatic logic [7:0] rand_bcd(input int limit);
        if ($urandom_range(0, 3) == 0)
            return 8'($urandom_range(0, 255));
        return int2bcd(int'($urandom_range(0, limit)));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_mode();
        case (m_field)
            0: begin
                m_hour  = m_capture(cur_hour, 23);
                m_min   = m_capture(cur_min, 59);
                m_sec   = m_capture(cur_sec, 59);
                m_field = 1;
            end
            1: m_field = 2;
            2: m_field = 3;
            default: begin
                m_field = 0;
                exp_loads++;
            end
        endcase
    endtask

    task automatic model_inc();
        case (m_field)
            1: m_hour = m_inc(m_hour, 24);
            2: m_min  = m_inc(m_min, 60);
            3: m_sec  = m_inc(m_sec, 60);
            default: ;
        endcase
    endtask

    task automatic check_model(input string tag);
        checkOutput({tag, ".field"}, 32'(edit_field), 32'(m_field));
        checkOutput({tag, ".active"}, 32'(set_active), 32'(m_field != 0));
        checkOutput({tag, ".hour"}, 32'(set_hour), 32'(m_hour));
        checkOutput({tag, ".min"}, 32'(set_min), 32'(m_min));
        checkOutput({tag, ".sec"}, 32'(set_sec), 32'(m_sec));
        checkOutput({tag, ".loads"}, 32'(load_count), 32'(exp_loads));
    endtask

    // Clean press of MODE and/or INC held well past the debounce window.
    task automatic applyStimulus(input logic mode, input logic inc, input string tag);
        int loads_before;
        loads_before = exp_loads;
        btn_mode_raw = mode;
        btn_inc_raw  = inc;
        step(DEB + 4);
        btn_mode_raw = 1'b0;
        btn_inc_raw  = 1'b0;
        step(DEB + 6);
        if (mode) model_mode();
        else if (inc) model_inc();
        check_model(tag);
        if (exp_loads != loads_before) begin
            checkOutput({tag, ".ld_hour"}, 32'(ld_hour), 32'(m_hour));
            checkOutput({tag, ".ld_min"}, 32'(ld_min), 32'(m_min));
            checkOutput({tag, ".ld_sec"}, 32'(ld_sec), 32'(m_sec));
        end
    endtask

    initial begin
        int waited;
        int first_rep, fall_edge, repeats;

        // reset and idle
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        step(50);
        check_model("reset_idle");
        checkOutput("reset_blink", 32'(blink_on), 32'd0);
        checkOutput("reset_load", 32'(load), 32'd0);

        // INC while idle is ignored
        applyStimulus(1'b0, 1'b1, "idle_inc");

        // 12:34:56, wrap hours through 23 -> 00, commit
        cur_hour = 8'h12; cur_min = 8'h34; cur_sec = 8'h56;
        applyStimulus(1'b1, 1'b0, "enter_1234");
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1, "hour_inc");
        checkOutput("hour_wrap", 32'(set_hour), 32'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "commit_1234");
        checkOutput("commit_loads", 32'(load_count), 32'd1);
        checkOutput("commit_ld_hour", 32'(ld_hour), 32'h00);
        checkOutput("commit_ld_min", 32'(ld_min), 32'h34);
        checkOutput("commit_ld_sec", 32'(ld_sec), 32'h56);

        // minutes carry 09 -> 10 and wrap 59 -> 00
        cur_hour = 8'h07; cur_min = 8'h09; cur_sec = 8'h00;
        applyStimulus(1'b1, 1'b0, "min09_enter");
        applyStimulus(1'b1, 1'b0, "min09_field");
        applyStimulus(1'b0, 1'b1, "min09_inc");
        checkOutput("min_carry", 32'(set_min), 32'h10);
        applyStimulus(1'b1, 1'b0, "min09_sec");
        applyStimulus(1'b1, 1'b0, "min09_commit");
        cur_min = 8'h59;
        applyStimulus(1'b1, 1'b0, "min59_enter");
        applyStimulus(1'b1, 1'b0, "min59_field");
        applyStimulus(1'b0, 1'b1, "min59_inc");
        checkOutput("min_wrap", 32'(set_min), 32'h00);
        checkOutput("min_wrap_hour", 32'(set_hour), 32'h07);
        applyStimulus(1'b1, 1'b0, "min59_sec");
        applyStimulus(1'b1, 1'b0, "min59_commit");

        // bounces shorter than the window are ignored
        cur_hour = 8'h05;
        applyStimulus(1'b1, 1'b0, "bounce_enter");
        btn_inc_raw = 1'b1; step(3);
        btn_inc_raw = 1'b0; step(2);
        btn_inc_raw = 1'b1; step(1);
        btn_inc_raw = 1'b0; step(1);
        btn_inc_raw = 1'b1; step(3);
        btn_inc_raw = 1'b0; step(12);
        checkOutput("bounce_ignored", 32'(set_hour), 32'h05);
        // press lands DEB+2 edges after first sample, value one edge later
        btn_inc_raw = 1'b1;
        step(DEB + 2);
        checkOutput("latency_before", 32'(set_hour), 32'h05);
        step(1);
        checkOutput("latency_after", 32'(set_hour), 32'h06);
        step(10 - (DEB + 3));
        btn_inc_raw = 1'b0;
        step(12);
        model_inc();
        check_model("held_single");
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "bounce_commit");

        // idle timeout aborts without load; blink starts high then toggles
        cur_hour = 8'h10; cur_min = 8'h20; cur_sec = 8'h30;
        btn_mode_raw = 1'b1;
        waited = 0;
        while (set_active !== 1'b1 && waited < 30) begin
            step(1);
            waited++;
        end
        checkOutput("to_entry", 32'(set_active), 32'd1);
        btn_mode_raw = 1'b0;
        model_mode();
        checkOutput("to_blink_entry", 32'(blink_on), 32'd1);
        step(BLINK - 1);
        checkOutput("to_blink_hold", 32'(blink_on), 32'd1);
        step(1);
        checkOutput("to_blink_toggle", 32'(blink_on), 32'd0);
        step(TIMEOUT - 1 - BLINK);
        checkOutput("to_before", 32'(set_active), 32'd1);
        step(1);
        m_field = 0;
        check_model("to_after");
        checkOutput("to_blink_off", 32'(blink_on), 32'd0);

        // reset mid-edit clears everything at once
        cur_hour = 8'h21; cur_min = 8'h45; cur_sec = 8'h12;
        applyStimulus(1'b1, 1'b0, "rst_enter");
        step(5);
        rst = 1'b1;
        #1;
        m_field = 0; m_hour = 8'h00; m_min = 8'h00; m_sec = 8'h00;
        check_model("rst_mid");
        checkOutput("rst_mid_load", 32'(load), 32'd0);
        checkOutput("rst_mid_blink", 32'(blink_on), 32'd0);
        step(2);
        rst = 1'b0;
        step(20);
        check_model("rst_after");

        // MODE and INC together: MODE wins
        cur_hour = 8'h08; cur_min = 8'h15; cur_sec = 8'h45;
        applyStimulus(1'b1, 1'b0, "both_enter");
        applyStimulus(1'b1, 1'b1, "both_press");
        checkOutput("both_hour", 32'(set_hour), 32'h08);
        applyStimulus(1'b1, 1'b0, "both_sec");
        applyStimulus(1'b1, 1'b0, "both_commit");

`ifdef CLOCK_TIME_SETTER_AUTOREPEAT_EN
        // held INC: one press step, then repeats while the debounced level stays high
        cur_hour = 8'h01; cur_min = 8'h02; cur_sec = 8'h00;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, "rep_enter");
        btn_inc_raw = 1'b1;
        step(40);
        btn_inc_raw = 1'b0;
        step(20);
        first_rep = (DEB + 2) + 1 + HOLD;
        fall_edge = 40 + DEB + 2;
        repeats   = (fall_edge - first_rep) / REPEAT + 1;
        for (int i = 0; i < 1 + repeats; i++) model_inc();
        check_model("autorepeat");
        checkOutput("autorepeat_sec", 32'(set_sec), 32'h05);
        applyStimulus(1'b1, 1'b0, "rep_commit");
`else
        first_rep = 0; fall_edge = 0; repeats = 0;
`endif

        // randomized sessions
        for (int s = 0; s < 8; s++) begin
            cur_hour = rand_bcd(23);
            cur_min  = rand_bcd(59);
            cur_sec  = rand_bcd(59);
            applyStimulus(1'b1, 1'b0, "rnd_enter");
            for (int k = 0; k < 30 && m_field != 0; k++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: applyStimulus(1'b0, 1'b1, "rnd_inc");
                    6, 7:             applyStimulus(1'b1, 1'b0, "rnd_mode");
                    default:          applyStimulus(1'b1, 1'b1, "rnd_both");
                endcase
            end
            for (int k = 0; k < 4 && m_field != 0; k++) applyStimulus(1'b1, 1'b0, "rnd_finish");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
